// File: rtl/costas_pd_lf_if.sv
// Sample/control bus between the carrier-recovery front end and the Costas
// phase detector / loop filter, plus the NCO frequency-correction result.
interface costas_pd_lf_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 30
);
    logic                 clken;
    logic                 din_valid;
    logic signed [DW-1:0] i_in;
    logic signed [DW-1:0] q_in;
    logic                 hold;
    logic                 clr;
    logic signed [AW-1:0] freq_mod_o;
    logic                 freq_valid;
    logic                 locked;

    modport master (
        output clken, din_valid, i_in, q_in, hold, clr,
        input  freq_mod_o, freq_valid, locked
    );

    modport slave (
        input  clken, din_valid, i_in, q_in, hold, clr,
        output freq_mod_o, freq_valid, locked
    );
endinterface

// File: rtl/costas_pd_lf.sv
// Polar-Costas phase detector (sign(I)*Q) feeding a saturating PI loop filter
// that drives the NCO frequency-modulation input, with a hysteretic lock detector.
module costas_pd_lf #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 30,
    parameter int unsigned KP_SH    = 12,
    parameter int unsigned KI_SH    = 4,
    parameter int unsigned LOCK_TH  = 2048,
    parameter int unsigned LOCK_CNT = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    costas_pd_lf_if.slave  bus
);
    localparam int unsigned SW = AW + 1;
    localparam int unsigned EW = DW + 1;

    localparam logic [0:0] ACQ    = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic signed [DW-1:0] E_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] E_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [AW-1:0] O_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] O_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [EW-1:0]        TH    = EW'(LOCK_TH);
    localparam logic [15:0]          CNT_END = 16'(LOCK_CNT);

    function automatic logic signed [AW-1:0] sat_aw(input logic signed [SW-1:0] x);
        if (x[SW-1] != x[SW-2]) begin
            return x[SW-1] ? O_MIN : O_MAX;
        end
        return x[AW-1:0];
    endfunction

    // Stage 1: phase error, with -(most negative) clamped to the positive max
    logic signed [DW-1:0] neg_q_c;
    logic signed [DW-1:0] pd_e_c;
    logic signed [DW-1:0] s1_e;
    logic                 s1_valid;

    always_comb begin
        neg_q_c = (bus.q_in == E_MIN) ? E_MAX : -bus.q_in;
        pd_e_c  = bus.i_in[DW-1] ? neg_q_c : bus.q_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_e     <= '0;
        end else if (bus.clken) begin
            s1_valid <= bus.din_valid;
            if (bus.din_valid) begin
                s1_e <= pd_e_c;
            end
        end
    end

    // Stage 2: proportional and integral paths
    logic signed [AW-1:0] e_kp_c;
    logic signed [AW-1:0] e_ki_c;
    logic signed [AW-1:0] integ_nxt_c;
    logic signed [AW-1:0] prop;
    logic signed [AW-1:0] integ;
    logic                 s2_valid;

    always_comb begin
        e_kp_c      = AW'(s1_e) <<< KP_SH;
        e_ki_c      = AW'(s1_e) <<< KI_SH;
        integ_nxt_c = sat_aw(SW'(integ) + SW'(e_ki_c));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            prop     <= '0;
            integ    <= '0;
        end else if (bus.clken) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                prop <= bus.hold ? '0 : e_kp_c;
            end
            if (bus.clr) begin
                integ <= '0;
            end else if (s1_valid && !bus.hold) begin
                integ <= integ_nxt_c;
            end
        end
    end

    // Lock detector: consecutive in-band / out-of-band run counters
    logic signed [EW-1:0] e_ext_c;
    logic [EW-1:0]        abs_e_c;
    logic                 in_band_c;
    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [15:0]          cnt_in;
    logic [15:0]          cnt_in_nxt;
    logic [15:0]          cnt_out;
    logic [15:0]          cnt_out_nxt;

    always_comb begin
        e_ext_c     = EW'(s1_e);
        abs_e_c     = e_ext_c[EW-1] ? EW'(-e_ext_c) : EW'(e_ext_c);
        in_band_c   = (abs_e_c < TH);
        state_nxt   = state;
        cnt_in_nxt  = cnt_in;
        cnt_out_nxt = cnt_out;
        if (s1_valid) begin
            if (state == ACQ) begin
                if (!in_band_c) begin
                    cnt_in_nxt = '0;
                end else if (cnt_in + 16'd1 == CNT_END) begin
                    state_nxt   = LOCKED;
                    cnt_in_nxt  = '0;
                    cnt_out_nxt = '0;
                end else begin
                    cnt_in_nxt = cnt_in + 16'd1;
                end
            end else begin
                if (in_band_c) begin
                    cnt_out_nxt = '0;
                end else if (cnt_out + 16'd1 == CNT_END) begin
                    state_nxt   = ACQ;
                    cnt_in_nxt  = '0;
                    cnt_out_nxt = '0;
                end else begin
                    cnt_out_nxt = cnt_out + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ACQ;
            cnt_in  <= '0;
            cnt_out <= '0;
        end else if (bus.clken) begin
            state   <= state_nxt;
            cnt_in  <= cnt_in_nxt;
            cnt_out <= cnt_out_nxt;
        end
    end

    // Stage 3: output sum; freq_valid drops during a stall so it never repeats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.freq_mod_o <= '0;
            bus.freq_valid <= 1'b0;
            bus.locked     <= 1'b0;
        end else begin
            bus.freq_valid <= bus.clken & s2_valid;
            if (bus.clken && s2_valid) begin
                bus.freq_mod_o <= sat_aw(SW'(prop) + SW'(integ));
                bus.locked     <= (state == LOCKED);
            end
        end
    end
endmodule

// File: tb/tb_costas_pd_lf.sv
// Bench for costas_pd_lf: directed vector table, multi-cycle corner sequences,
// and randomized streams checked against an arithmetic reference model.
module tb_costas_pd_lf;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 30;
    localparam longint OMAX = 536870911;
    localparam longint OMIN = -536870912;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    costas_pd_lf_if #(.DW(DW), .AW(AW)) bus ();

    costas_pd_lf #(
        .DW(DW), .AW(AW), .KP_SH(12), .KI_SH(4), .LOCK_TH(2048), .LOCK_CNT(64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int     i;
        int     q;
        bit     hold;
        bit     clr;
        longint exp_fm;
        bit     exp_lk;
    } vec_t;

    typedef struct {
        longint fm;
        bit     lk;
    } exp_t;

    int     n_pass  = 0;
    int     n_total = 0;
    exp_t   exp_q[$];
    bit     mon_en  = 1'b0;
    longint m_integ;
    bit     m_lk;
    int     m_cin;
    int     m_cout;

    function automatic longint clamp(input longint x);
        if (x > OMAX) return OMAX;
        if (x < OMIN) return OMIN;
        return x;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic void model_reset();
        m_integ = 0;
        m_lk    = 1'b0;
        m_cin   = 0;
        m_cout  = 0;
        exp_q.delete();
    endfunction

    // Reference: error from the sign rule, PI filter in plain 64-bit arithmetic
    function automatic void model_push(input int i, input int q);
        longint e;
        longint ae;
        exp_t   x;
        e = (i >= 0) ? longint'(q) : -longint'(q);
        if (e > 32767) e = 32767;
        ae = (e < 0) ? -e : e;
        m_integ = clamp(m_integ + e * 16);
        if (!m_lk) begin
            if (ae < 2048) begin
                m_cin++;
                if (m_cin == 64) begin m_lk = 1'b1; m_cin = 0; m_cout = 0; end
            end else m_cin = 0;
        end else begin
            if (ae >= 2048) begin
                m_cout++;
                if (m_cout == 64) begin m_lk = 1'b0; m_cin = 0; m_cout = 0; end
            end else m_cout = 0;
        end
        x.fm = clamp(e * 4096 + m_integ);
        x.lk = m_lk;
        exp_q.push_back(x);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.clken     = 1'b1;
        bus.din_valid = 1'b0;
        bus.i_in      = '0;
        bus.q_in      = '0;
        bus.hold      = 1'b0;
        bus.clr       = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        model_reset();
    endtask

    task automatic drive_sample(input int i, input int q);
        bus.din_valid = 1'b1;
        bus.i_in      = 16'(i);
        bus.q_in      = 16'(q);
        if (mon_en && bus.clken) model_push(i, q);
        step();
        bus.din_valid = 1'b0;
    endtask

    task automatic drain();
        bus.din_valid = 1'b0;
        bus.clken     = 1'b1;
        repeat (6) step();
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int lat;
        bus.hold = v.hold;
        if (v.clr) begin
            bus.clr = 1'b1;
            step();
            bus.clr = 1'b0;
        end
        drive_sample(v.i, v.q);
        lat = 1;
        while (!bus.freq_valid && lat < 12) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, longint'(lat), 3);
        check({tag, "_fm"}, longint'(bus.freq_mod_o), v.exp_fm);
        check({tag, "_lk"}, longint'(bus.locked), longint'(v.exp_lk));
        step();
        check({tag, "_pulse_end"}, longint'(bus.freq_valid), 0);
        bus.hold = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && reset_n && bus.freq_valid) begin
            exp_t x;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                x = exp_q.pop_front();
                check("stream_fm", longint'(bus.freq_mod_o), x.fm);
                check("stream_lk", longint'(bus.locked), longint'(x.lk));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        int   pulses;
        int   mode;
        int   iv;
        int   qv;

        vecs[0] = '{100,    1000,   1'b0, 1'b0, 4112000,    1'b0};
        vecs[1] = '{-5,     1000,   1'b0, 1'b0, -4096000,   1'b0};
        vecs[2] = '{0,      -7,     1'b0, 1'b0, -28784,     1'b0};
        vecs[3] = '{-1,     -32768, 1'b0, 1'b1, 134737904,  1'b0};
        vecs[4] = '{1,      1000,   1'b1, 1'b0, 524272,     1'b0};
        vecs[5] = '{1,      1000,   1'b0, 1'b1, 4112000,    1'b0};
        vecs[6] = '{-32768, 0,      1'b0, 1'b0, 16000,      1'b0};
        vecs[7] = '{32767,  -32768, 1'b0, 1'b0, -134726016, 1'b0};

        do_reset();
        check("reset_fm", longint'(bus.freq_mod_o), 0);
        check("reset_fv", longint'(bus.freq_valid), 0);
        check("reset_lk", longint'(bus.locked), 0);

        for (int k = 0; k < 8; k++) apply_vec(vecs[k], $sformatf("vec%0d", k));

        // Reset with a sample in flight: outputs clear and the sample is lost
        drive_sample(1, 1000);
        reset_n = 1'b0;
        #1;
        check("midrst_fm", longint'(bus.freq_mod_o), 0);
        check("midrst_fv", longint'(bus.freq_valid), 0);
        check("midrst_lk", longint'(bus.locked), 0);
        repeat (2) step();
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.freq_valid) pulses++;
        end
        check("midrst_no_valid", longint'(pulses), 0);
        apply_vec(vecs[0], "post_rst");

        // Stall for 5 cycles mid-pipeline; a strobe during the stall is ignored
        drive_sample(1, 1000);
        lat = 1;
        step();
        lat++;
        bus.clken     = 1'b0;
        bus.din_valid = 1'b1;
        bus.i_in      = 16'(1);
        bus.q_in      = 16'(30000);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            lat++;
            if (bus.freq_valid) pulses++;
        end
        bus.clken     = 1'b1;
        bus.din_valid = 1'b0;
        while (!bus.freq_valid && lat < 20) begin
            step();
            lat++;
        end
        check("stall_latency", longint'(lat), 8);
        check("stall_fm", longint'(bus.freq_mod_o), 4128000);
        check("stall_no_valid", longint'(pulses), 0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.freq_valid) pulses++;
        end
        check("stall_ignored_input", longint'(pulses), 0);

        // Integrator saturation, both directions
        do_reset();
        mon_en = 1'b1;
        for (int c = 0; c < 1100; c++) drive_sample(-1, -32768);
        drain();
        check("sat_pos_final", longint'(bus.freq_mod_o), OMAX);
        for (int c = 0; c < 2200; c++) drive_sample(1, -32768);
        drain();
        check("sat_neg_final", longint'(bus.freq_mod_o), OMIN);

        // Lock entry, a broken out-of-band run, then lock loss
        do_reset();
        for (int c = 0; c < 63; c++) drive_sample(1, 100);
        drain();
        check("lock_63_not_yet", longint'(bus.locked), 0);
        drive_sample(1, 100);
        drain();
        check("lock_rise", longint'(bus.locked), 1);
        for (int c = 0; c < 63; c++) drive_sample(1, 5000);
        drive_sample(1, 100);
        drain();
        check("lock_kept", longint'(bus.locked), 1);
        for (int c = 0; c < 64; c++) drive_sample(1, 5000);
        drain();
        check("lock_fall", longint'(bus.locked), 0);

        // Random segments: in-band, out-of-band or mixed errors, random stalls
        do_reset();
        for (int s = 0; s < 15; s++) begin
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 200; c++) begin
                iv = int'($urandom_range(0, 65535)) - 32768;
                case (mode)
                    0: qv = int'($urandom_range(0, 3000)) - 1500;
                    1: begin
                        qv = int'($urandom_range(2048, 32767));
                        if ($urandom_range(0, 1) == 1) qv = -qv;
                        if ($urandom_range(0, 15) == 0) qv = -32768;
                    end
                    default: qv = int'($urandom_range(0, 65535)) - 32768;
                endcase
                bus.clken     = ($urandom_range(0, 3) != 0);
                bus.din_valid = ($urandom_range(0, 9) < 7);
                bus.i_in      = 16'(iv);
                bus.q_in      = 16'(qv);
                if (bus.clken && bus.din_valid) model_push(iv, qv);
                step();
            end
        end
        drain();
        check("rand_drain", longint'(exp_q.size()), 0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/costas_pd_lf.md
# costas_pd_lf

Polar-Costas phase detector and PI loop filter for the carrier-recovery loop. It takes baseband I/Q samples produced by the mixer/low-pass chain that follows the NCO and computes the phase error sign(I)·Q. It filters that error with a proportional-plus-integral loop filter and drives the NCO's frequency-modulation input (`freq_mod_i`, 30 bits) with a saturated signed word. It also reports carrier lock.

## Interface
- `DW`, 16, signed I/Q input width
- `AW`, 30, output width; equals the NCO `aprf`. Constraint: `DW+KP_SH <= AW-1` and `DW+KI_SH <= AW-1`
- `KP_SH`, 12, proportional gain as a left shift (Kp = 2^KP_SH)
- `KI_SH`, 4, integral gain as a left shift (Ki = 2^KI_SH)
- `LOCK_TH`, 2048, |e| strictly below this counts as in-band
- `LOCK_CNT`, 64, consecutive samples needed to enter or leave lock (max 65535)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `clken`  in  1  global clock enable; when low, every register holds
- `din_valid`  in  1  I/Q sample strobe
- `i_in`  in  DW  signed I sample
- `q_in`  in  DW  signed Q sample
- `hold`  in  1  freeze the integrator and zero the proportional path
- `clr`  in  1  synchronous integrator clear
- `freq_mod_o`  out  AW  signed frequency correction to the NCO `freq_mod_i`
- `freq_valid`  out  1  one-cycle pulse marking a new `freq_mod_o`
- `locked`  out  1  lock indicator

## Operation
- **Stage 1 (PD), registered when `clken & din_valid`:**
  - e = q_in if i_in >= 0 (I = 0 is treated as positive); otherwise e = −q_in.
  - −(−2^(DW−1)) saturates to 2^(DW−1)−1.
  - e is DW bits signed. A stage-1 valid bit is registered alongside it.
- **Stage 2 (LF), on stage-1 valid:**
  - prop = sign-extend(e) << KP_SH, or 0 when `hold`=1.
  - integ_next = integ + (sign-extend(e) << KI_SH), computed AW+1 wide and saturated to [−2^(AW−1), 2^(AW−1)−1].
  - integ is unchanged when `hold`=1.
  - `clr`=1 (with `clken`) forces integ to 0 and takes priority over `hold` and over accumulation, whether or not a sample is present.
  - prop, integ and the stage-2 valid bit are registered.
- **Stage 3 (output):**
  - freq_mod_o = sat_AW(prop + integ), summed AW+1 wide.
  - `freq_valid` = stage-2 valid. Between pulses, freq_mod_o holds its last value.
- **Lock FSM**, evaluated per stage-1 sample:
  - States: ACQ and LOCKED. Two 16-bit counters: cnt_in and cnt_out.
  - ACQ, |e| < LOCK_TH: cnt_in++. When cnt_in reaches LOCK_CNT → LOCKED, and both counters clear.
  - ACQ, |e| >= LOCK_TH: cnt_in = 0.
  - LOCKED, |e| >= LOCK_TH: cnt_out++. When cnt_out reaches LOCK_CNT → ACQ, and both counters clear.
  - LOCKED, |e| < LOCK_TH: cnt_out = 0.
  - |e| is computed DW+1 wide, so |−2^(DW−1)| is not misread.
  - `locked` is registered at stage 3, aligned with the `freq_valid` of the sample that caused the transition.
  - `hold` and `clr` do not affect the FSM.

## Timing
- **Reset (async, `reset_n`=0):** freq_mod_o=0, freq_valid=0, locked=0, integ=0, pipeline valids=0, FSM=ACQ, both counters 0. Outputs are valid immediately after reset.
- **Latency:** a sample accepted at edge n (with `clken`=1 at edges n, n+1, n+2) gives `freq_valid`=1 and the new freq_mod_o after edge n+2, i.e. 3 clocks.
- **Throughput:** one sample per clock. Back-to-back `din_valid` is supported with no bubbles.
- **Stalls:** `clken`=0 stalls the whole pipeline. `freq_valid` is asserted only in cycles where `clken`=1 and is not re-issued during a stall.
- **Ignored input:** `din_valid` is ignored while `clken`=0.
- **Reset mid-operation:** all in-flight samples are discarded and no `freq_valid` is produced for them.

## Test plan
1. **Reset:** assert `reset_n`=0 mid-stream → next cycle freq_mod_o=0, freq_valid=0, locked=0. The first sample after release is processed from integ=0.
2. **Single sample:** I=100, Q=1000 → 3 clocks later freq_valid pulses once with freq_mod_o = 4096000+16000 = 4112000. A second sample I=−5, Q=1000 → freq_mod_o = −4096000 + (16000−16000) = −4096000.
3. **Edge values:**
   - I=0, Q=−7 → e=−7.
   - I=−1, Q=−32768 → e=32767, giving freq_mod_o = 134213632+524272.
4. **Integrator saturation:** stream e=32767 continuously → integ climbs by 524272 per sample and clamps at 536870911. freq_mod_o stays 536870911 and never wraps negative. The symmetric negative stream clamps at −536870912.
5. **Lock:**
   - 64 samples with I=1, Q=100 → locked rises with the 64th freq_valid.
   - 63 samples with Q=5000 and then one with Q=100 → locked stays 1.
   - 64 consecutive samples with Q=5000 → locked falls with the 64th.
6. **Controls:**
   - `hold`=1 with samples e=1000 → freq_mod_o equals the frozen integ.
   - `clr` pulse without a sample → integ=0; the next sample with e=1000 → 4112000.
   - `clken` low for 5 cycles mid-pipeline → output delayed by exactly 5 cycles, values unchanged.
